// File: rtl/log_comp_sequencer.sv
// Serial log-compression controller: reads each mel energy from RAM, takes its MSB index
// through one shared encoder and streams the result over a back-pressurable valid/ready port.
module log_comp_sequencer #(
   parameter int N_FILTERS = 40,
   parameter int IN_WIDTH  = 28,
   parameter int OUT_WIDTH = 6,
   parameter int IDX_WIDTH = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic                 mem_rd_en,
   output logic [IDX_WIDTH-1:0] mem_rd_addr,
   input  logic [IN_WIDTH-1:0]  mem_rd_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic [IDX_WIDTH-1:0] out_idx,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done,
   output logic                 overrun,
   output logic [15:0]          frame_cnt
);

   typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_FILTERS - 1);

   state_t               state;
   state_t               state_nx;
   logic [IDX_WIDTH-1:0] k;
   logic [IDX_WIDTH-1:0] k_nx;
   logic [OUT_WIDTH-1:0] log_val;
   logic                 transfer;

   // Shared MSB-index encoder; an all-zero word maps to 0 just like a word of 1.
   always_comb begin
      log_val = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (mem_rd_data[i]) log_val = OUT_WIDTH'(i);
      end
   end

   always_comb begin
      state_nx = state;
      k_nx     = k;
      transfer = (state == EMIT) && out_ready;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nx = READ;
               k_nx     = '0;
            end
         end
         READ: state_nx = abort ? IDLE : WAIT;
         WAIT: state_nx = abort ? IDLE : EMIT;
         EMIT: begin
            if (abort) begin
               state_nx = IDLE;
            end else if (transfer) begin
               if (k == LAST_IDX) begin
                  state_nx = DONE;
               end else begin
                  state_nx = READ;
                  k_nx     = k + IDX_WIDTH'(1);
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Every output is a flop loaded from the next state, so it lines up with the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         k           <= '0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_idx     <= '0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         overrun     <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         state       <= state_nx;
         k           <= k_nx;
         mem_rd_en   <= (state_nx == READ);
         mem_rd_addr <= k_nx;
         out_valid   <= (state_nx == EMIT);
         busy        <= (state_nx == READ) || (state_nx == WAIT) || (state_nx == EMIT);
         done        <= (state_nx == DONE);
         overrun     <= start && (state != IDLE);
         if (state == WAIT && state_nx == EMIT) begin
            out_data <= log_val;
            out_idx  <= k;
            out_last <= (k == LAST_IDX);
         end
         if (state_nx == DONE) frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_log_comp_sequencer.sv
// Directed bench for log_comp_sequencer; cycle c is the period that ends at the c-th edge
// after the edge that samples start.
module tb_log_comp_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic        abort;
   logic        mem_rd_en;
   logic [5:0]  mem_rd_addr;
   logic [27:0] mem_rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_data;
   logic [5:0]  out_idx;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        overrun;
   logic [15:0] frame_cnt;

   logic [27:0] ram [0:63];

   int vectors;
   int miscompares;
   int exp_frames;

   int   n_out, done_cycle, ndone, n_ovr, hold_err, first_rd, first_valid, rd_tail, valid_tail;
   bit   timed_out;
   logic [5:0] got_data [0:63];
   logic [5:0] got_idx  [0:63];
   logic       got_last [0:63];

   log_comp_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_idx     (out_idx),
      .out_last    (out_last),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun),
      .frame_cnt   (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
   end

   // floor(log2(e)) expressed through $clog2, with 0 mapped to 0.
   function automatic logic [5:0] exp_log(input logic [27:0] e);
      longint v;
      v = longint'(e);
      if (v == 0) return 6'd0;
      return 6'($clog2(v + 1) - 1);
   endfunction

   // Drives one frame from the current negedge and records what the DUT emits.
   task automatic run_frame(input int stall_idx, input int stall_len, input int start_emit_idx,
                            input bit start_in_done, input int abort_idx);
      int   stalls, tail;
      bit   ended, pulsed, prev_hold;
      logic [5:0] pd, pi;
      logic pl;
      n_out = 0; done_cycle = -1; ndone = 0; n_ovr = 0; hold_err = 0;
      first_rd = -1; first_valid = -1; rd_tail = 0; valid_tail = 0; timed_out = 1'b0;
      stalls = 0; tail = 5; ended = 1'b0; pulsed = 1'b0; prev_hold = 1'b0;
      pd = '0; pi = '0; pl = 1'b0;
      start = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         start = 1'b0; abort = 1'b0; out_ready = 1'b1;
         if (mem_rd_en && first_rd < 0) first_rd = c;
         if (mem_rd_en && ended) rd_tail++;
         if (out_valid && first_valid < 0) first_valid = c;
         if (out_valid && ended) valid_tail++;
         if (overrun) n_ovr++;
         if (done) begin
            ndone++;
            if (done_cycle < 0) done_cycle = c;
         end
         if (prev_hold && (!out_valid || out_data !== pd || out_idx !== pi || out_last !== pl))
            hold_err++;
         prev_hold = 1'b0;
         if (!ended && out_valid) begin
            if (int'(out_idx) == stall_idx && stalls < stall_len) begin
               out_ready = 1'b0;
               stalls++;
            end
            if (int'(out_idx) == abort_idx) begin
               abort = 1'b1; out_ready = 1'b0; ended = 1'b1;
            end
            if (int'(out_idx) == start_emit_idx && !pulsed) begin
               start = 1'b1; pulsed = 1'b1;
            end
            if (out_ready) begin
               if (n_out < 64) begin
                  got_data[n_out] = out_data;
                  got_idx[n_out]  = out_idx;
                  got_last[n_out] = out_last;
               end
               n_out++;
            end else if (!abort) begin
               prev_hold = 1'b1; pd = out_data; pi = out_idx; pl = out_last;
            end
         end
         if (done && !ended) begin
            ended = 1'b1;
            if (start_in_done) start = 1'b1;
         end
         if (ended) begin
            if (tail == 0) break;
            tail--;
         end
      end
      if (!ended) timed_out = 1'b1;
      start = 1'b0; abort = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      vectors++; if (mem_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_rd_en: got %b expected 0", mem_rd_en); end
      vectors++; if (mem_rd_addr !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_mem_rd_addr: got %0d expected 0", mem_rd_addr); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
      vectors++; if (out_data !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_out_data: got %0d expected 0", out_data); end
      vectors++; if (out_idx !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_out_idx: got %0d expected 0", out_idx); end
      vectors++; if (out_last !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_last: got %b expected 0", out_last); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
      vectors++; if (frame_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
      start = 1'b0; rst = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_beats_start: busy %b rd_en %b expected 0 0", busy, mem_rd_en); end
      exp_frames = 0;
   endtask

   task automatic test_ramp();
      for (int k = 0; k < 64; k++) ram[k] = 28'(k + 1);
      run_frame(-1, 0, -1, 1'b0, -1);
      exp_frames++;
      vectors++; if (timed_out) begin miscompares++; $display("[TB] FAIL ramp_timeout: got no done expected done"); end
      vectors++; if (first_rd != 1) begin miscompares++; $display("[TB] FAIL ramp_first_read: got cycle %0d expected 1", first_rd); end
      vectors++; if (first_valid != 3) begin miscompares++; $display("[TB] FAIL ramp_first_valid: got cycle %0d expected 3", first_valid); end
      vectors++; if (n_out != 40) begin miscompares++; $display("[TB] FAIL ramp_count: got %0d expected 40", n_out); end
      for (int k = 0; k < 40 && k < n_out; k++) begin
         vectors++;
         if (got_data[k] !== exp_log(28'(k + 1)) || got_idx[k] !== 6'(k) || got_last[k] !== (k == 39)) begin
            miscompares++;
            $display("[TB] FAIL ramp_out[%0d]: got data %0d idx %0d last %b expected %0d %0d %b",
                     k, got_data[k], got_idx[k], got_last[k], exp_log(28'(k + 1)), k, k == 39);
         end
      end
      vectors++; if (done_cycle != 121 || ndone != 1) begin miscompares++; $display("[TB] FAIL ramp_done: got cycle %0d pulses %0d expected 121 1", done_cycle, ndone); end
      vectors++; if (frame_cnt !== 16'(exp_frames)) begin miscompares++; $display("[TB] FAIL ramp_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
      vectors++; if (busy !== 1'b0 || rd_tail != 0) begin miscompares++; $display("[TB] FAIL ramp_idle_after: busy %b reads %0d expected 0 0", busy, rd_tail); end
   endtask

   task automatic test_values();
      logic [5:0] fixed_exp [0:3];
      fixed_exp[0] = 6'd0; fixed_exp[1] = 6'd0; fixed_exp[2] = 6'd27; fixed_exp[3] = 6'd7;
      ram[0] = 28'h0000000; ram[1] = 28'h0000001; ram[2] = 28'h8000000; ram[3] = 28'h00000FF;
      for (int k = 4; k < 39; k++) ram[k] = 28'($urandom) >> (k % 28);
      ram[39] = 28'hFFFFFFF;
      run_frame(-1, 0, -1, 1'b0, -1);
      exp_frames++;
      vectors++; if (n_out != 40 || timed_out) begin miscompares++; $display("[TB] FAIL values_count: got %0d expected 40", n_out); end
      for (int k = 0; k < 4; k++) begin
         vectors++; if (got_data[k] !== fixed_exp[k]) begin miscompares++; $display("[TB] FAIL values_fixed[%0d]: got %0d expected %0d", k, got_data[k], fixed_exp[k]); end
      end
      for (int k = 4; k < 40 && k < n_out; k++) begin
         vectors++; if (got_data[k] !== exp_log(ram[k])) begin miscompares++; $display("[TB] FAIL values_data[%0d]: got %0d expected %0d", k, got_data[k], exp_log(ram[k])); end
      end
      for (int k = 0; k < 40 && k < n_out; k++) begin
         vectors++; if (got_last[k] !== (k == 39)) begin miscompares++; $display("[TB] FAIL values_last[%0d]: got %b expected %b", k, got_last[k], k == 39); end
      end
      vectors++; if (frame_cnt !== 16'(exp_frames)) begin miscompares++; $display("[TB] FAIL values_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
   endtask

   task automatic test_stall();
      for (int k = 0; k < 40; k++) ram[k] = 28'h1 << (k % 28);
      run_frame(10, 5, -1, 1'b0, -1);
      exp_frames++;
      vectors++; if (n_out != 40 || timed_out) begin miscompares++; $display("[TB] FAIL stall_count: got %0d expected 40", n_out); end
      vectors++; if (hold_err != 0) begin miscompares++; $display("[TB] FAIL stall_hold: got %0d changes expected 0", hold_err); end
      vectors++; if (got_idx[10] !== 6'd10 || got_data[10] !== 6'd10 || got_idx[11] !== 6'd11) begin miscompares++; $display("[TB] FAIL stall_idx10: got idx %0d data %0d next %0d expected 10 10 11", got_idx[10], got_data[10], got_idx[11]); end
      vectors++; if (done_cycle != 126) begin miscompares++; $display("[TB] FAIL stall_done: got cycle %0d expected 126", done_cycle); end
      vectors++; if (frame_cnt !== 16'(exp_frames)) begin miscompares++; $display("[TB] FAIL stall_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
   endtask

   task automatic test_overrun();
      run_frame(-1, 0, 5, 1'b1, -1);
      exp_frames++;
      vectors++; if (n_ovr != 2) begin miscompares++; $display("[TB] FAIL overrun_pulses: got %0d expected 2", n_ovr); end
      vectors++; if (n_out != 40) begin miscompares++; $display("[TB] FAIL overrun_count: got %0d expected 40", n_out); end
      vectors++; if (done_cycle != 121 || ndone != 1) begin miscompares++; $display("[TB] FAIL overrun_done: got cycle %0d pulses %0d expected 121 1", done_cycle, ndone); end
      vectors++; if (rd_tail != 0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL overrun_restart: reads %0d busy %b expected 0 0", rd_tail, busy); end
      vectors++; if (frame_cnt !== 16'(exp_frames)) begin miscompares++; $display("[TB] FAIL overrun_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
   endtask

   task automatic test_abort();
      run_frame(-1, 0, -1, 1'b0, 20);
      vectors++; if (n_out != 20) begin miscompares++; $display("[TB] FAIL abort_count: got %0d expected 20", n_out); end
      vectors++; if (valid_tail != 0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_idle: valid cycles %0d busy %b expected 0 0", valid_tail, busy); end
      vectors++; if (ndone != 0) begin miscompares++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", ndone); end
      vectors++; if (frame_cnt !== 16'(exp_frames)) begin miscompares++; $display("[TB] FAIL abort_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      vectors++; if (overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_start_overrun: got %b expected 0", overrun); end
      @(negedge clk);
      vectors++; if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_start_idle: busy %b rd_en %b expected 0 0", busy, mem_rd_en); end
      run_frame(-1, 0, -1, 1'b0, -1);
      exp_frames++;
      vectors++; if (n_out != 40 || got_idx[0] !== 6'd0) begin miscompares++; $display("[TB] FAIL abort_restart: got %0d outputs first idx %0d expected 40 0", n_out, got_idx[0]); end
      vectors++; if (done_cycle != 121) begin miscompares++; $display("[TB] FAIL abort_restart_done: got cycle %0d expected 121", done_cycle); end
      vectors++; if (frame_cnt !== 16'(exp_frames)) begin miscompares++; $display("[TB] FAIL abort_restart_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames); end
   endtask

   task automatic test_reset_midframe();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0 || done !== 1'b0 || out_data !== 6'd0) begin
         miscompares++; $display("[TB] FAIL midreset_outputs: valid %b busy %b rd_en %b done %b data %0d expected all 0", out_valid, busy, mem_rd_en, done, out_data);
      end
      vectors++; if (frame_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL midreset_frame_cnt: got %0d expected 0", frame_cnt); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midreset_stays_idle: valid %b busy %b expected 0 0", out_valid, busy); end
      force dut.frame_cnt = 16'hFFFF;
      #1;
      release dut.frame_cnt;
      @(negedge clk);
      run_frame(-1, 0, -1, 1'b0, -1);
      vectors++; if (done_cycle != 121) begin miscompares++; $display("[TB] FAIL wrap_done: got cycle %0d expected 121", done_cycle); end
      vectors++; if (frame_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL wrap_frame_cnt: got %0h expected 0", frame_cnt); end
   endtask

   initial begin
      vectors = 0; miscompares = 0; exp_frames = 0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 64; k++) ram[k] = '0;
      test_reset();
      test_ramp();
      test_values();
      test_stall();
      test_overrun();
      test_abort();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
